// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared definitions for the 1x3 router control path:
//                header field widths, state encodings and the Moore output
//                decode used by router_fsm_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;
    localparam int STATE_W   = 3;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    localparam logic [STATE_W-1:0] DECODE_ADDRESS     = 3'b000;
    localparam logic [STATE_W-1:0] LOAD_FIRST_DATA    = 3'b001;
    localparam logic [STATE_W-1:0] LOAD_DATA          = 3'b010;
    localparam logic [STATE_W-1:0] LOAD_PARITY        = 3'b011;
    localparam logic [STATE_W-1:0] CHECK_PARITY_ERROR = 3'b100;
    localparam logic [STATE_W-1:0] FIFO_FULL_STATE    = 3'b101;
    localparam logic [STATE_W-1:0] LOAD_AFTER_FULL    = 3'b110;
    localparam logic [STATE_W-1:0] WAIT_TILL_EMPTY    = 3'b111;

    // Strobe bundle driven by the sequencing FSM
    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic write_enb_reg;
        logic rst_int_reg;
        logic busy;
    } fsm_out_t;

    // Selects the per-port flag addressed by a header; the invalid address
    // selects nothing so it can never trigger a transition.
    function automatic logic port_bit(input logic [NUM_PORTS-1:0] flags,
                                      input logic [ADDR_W-1:0]    addr);
        logic r;
        r = 1'b0;
        case (addr)
            2'd0:    r = flags[0];
            2'd1:    r = flags[1];
            2'd2:    r = flags[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Moore output decode: every strobe is a pure function of the state
    function automatic fsm_out_t decode_outputs(input logic [STATE_W-1:0] state);
        fsm_out_t o;
        o = '0;
        case (state)
            DECODE_ADDRESS: begin
                o.detect_add = 1'b1;
            end
            LOAD_FIRST_DATA: begin
                o.lfd_state = 1'b1;
                o.busy      = 1'b1;
            end
            LOAD_DATA: begin
                o.ld_state      = 1'b1;
                o.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                o.write_enb_reg = 1'b1;
                o.busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                o.rst_int_reg = 1'b1;
                o.busy        = 1'b1;
            end
            FIFO_FULL_STATE: begin
                o.full_state = 1'b1;
                o.busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                o.laf_state     = 1'b1;
                o.write_enb_reg = 1'b1;
                o.busy          = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                o.busy = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_fsm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : router_fsm_ctrl
//  Description : Packet-sequencing controller for the 1x3 router. Decodes the
//                header address and drives the write-side datapath strobes
//                and the upstream busy stall, one packet at a time.
//                Optional feature macro: ROUTER_FSM_SOFT_RESET_EN -- when
//                defined, a soft reset of the addressed port aborts the
//                packet and returns to DECODE_ADDRESS.
//  Revision    : 1.0  initial release
// ============================================================================
module router_fsm_ctrl
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic [STATE_W-1:0] fsm_state
);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_next_state;
    logic [ADDR_W-1:0]    r_addr_q;
    fsm_out_t             r_out;
    logic [NUM_PORTS-1:0] w_empty_vec;
    logic                 w_hdr_empty;
    logic                 w_held_empty;
    logic                 w_soft_hit;

    assign w_empty_vec  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_hdr_empty  = port_bit(w_empty_vec, data_in);
    assign w_held_empty = port_bit(w_empty_vec, r_addr_q);

`ifdef ROUTER_FSM_SOFT_RESET_EN
    // Only the port owning the current packet may abort it
    assign w_soft_hit = port_bit({soft_reset_2, soft_reset_1, soft_reset_0}, r_addr_q);
`else
    logic w_unused_soft;
    assign w_unused_soft = soft_reset_0 ^ soft_reset_1 ^ soft_reset_2;
    assign w_soft_hit    = 1'b0;
`endif

    // Next-state selection; soft-reset abort outranks every normal transition
    always_comb begin
        w_next_state = r_state;
        if (w_soft_hit) begin
            w_next_state = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && (data_in != INVALID_ADDR)) begin
                        w_next_state = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: begin
                    w_next_state = LOAD_DATA;
                end
                LOAD_DATA: begin
                    // A full FIFO wins over the end-of-payload indication
                    if (fifo_full) begin
                        w_next_state = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        w_next_state = LOAD_PARITY;
                    end
                end
                LOAD_PARITY: begin
                    w_next_state = CHECK_PARITY_ERROR;
                end
                CHECK_PARITY_ERROR: begin
                    w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        w_next_state = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        w_next_state = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        w_next_state = LOAD_PARITY;
                    end else begin
                        w_next_state = LOAD_DATA;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (w_held_empty) begin
                        w_next_state = LOAD_FIRST_DATA;
                    end
                end
                default: w_next_state = DECODE_ADDRESS;
            endcase
        end
    end

    // State, header address and strobes registered together; strobes are
    // decoded from the next state so they line up with the state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= DECODE_ADDRESS;
            r_addr_q <= '0;
            r_out    <= decode_outputs(DECODE_ADDRESS);
        end else begin
            r_state <= w_next_state;
            r_out   <= decode_outputs(w_next_state);
            if ((r_state == DECODE_ADDRESS) && pkt_valid) begin
                r_addr_q <= data_in;
            end
        end
    end

    assign detect_add    = r_out.detect_add;
    assign lfd_state     = r_out.lfd_state;
    assign ld_state      = r_out.ld_state;
    assign laf_state     = r_out.laf_state;
    assign full_state    = r_out.full_state;
    assign write_enb_reg = r_out.write_enb_reg;
    assign rst_int_reg   = r_out.rst_int_reg;
    assign busy          = r_out.busy;
    assign fsm_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_fsm_ctrl
//  Description : Self-checking bench for router_fsm_ctrl: directed packet
//                scenarios followed by randomized traffic, all compared
//                against a behavioural packet-sequencing model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_router_fsm_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b1;
    logic       fifo_empty_1 = 1'b1;
    logic       fifo_empty_2 = 1'b1;
    logic       soft_reset_0 = 1'b0;
    logic       soft_reset_1 = 1'b0;
    logic       soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    router_fsm_ctrl u_dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
        .fsm_state     (fsm_state)
    );

    always #5 clock = ~clock;

    // Reference model: phase names mirror the packet life cycle
    localparam int P_DECODE = 0, P_LFD = 1, P_LD = 2, P_PARITY = 3,
                   P_CHECK = 4, P_FULL = 5, P_LAF = 6, P_WAIT = 7;

    // Expected strobes per phase:
    // {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy}
    logic [7:0] exp_tab [8] = '{8'h80, 8'h41, 8'h24, 8'h05, 8'h03, 8'h09, 8'h15, 8'h01};

    int         m_phase = P_DECODE;
    int         m_addr  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit empty_of(input int port);
        if (port == 0) return fifo_empty_0;
        if (port == 1) return fifo_empty_1;
        if (port == 2) return fifo_empty_2;
        return 1'b0;
    endfunction

    function automatic bit soft_of(input int port);
        if (port == 0) return soft_reset_0;
        if (port == 1) return soft_reset_1;
        if (port == 2) return soft_reset_2;
        return 1'b0;
    endfunction

    // Advance the model using the inputs present at this clock edge
    task automatic model_step();
        int nxt;
        int new_addr;
        nxt      = m_phase;
        new_addr = m_addr;
        if (m_phase == P_DECODE && pkt_valid) new_addr = int'(data_in);
        if (reset) begin
            nxt      = P_DECODE;
            new_addr = 0;
        end else begin
            bit aborted;
            aborted = 1'b0;
`ifdef ROUTER_FSM_SOFT_RESET_EN
            aborted = soft_of(m_addr);
`endif
            if (aborted) nxt = P_DECODE;
            else if (m_phase == P_DECODE) begin
                if (pkt_valid && data_in != 2'd3)
                    nxt = empty_of(int'(data_in)) ? P_LFD : P_WAIT;
            end
            else if (m_phase == P_LFD)    nxt = P_LD;
            else if (m_phase == P_LD)     nxt = fifo_full ? P_FULL : (!pkt_valid ? P_PARITY : P_LD);
            else if (m_phase == P_PARITY) nxt = P_CHECK;
            else if (m_phase == P_CHECK)  nxt = fifo_full ? P_FULL : P_DECODE;
            else if (m_phase == P_FULL)   nxt = fifo_full ? P_FULL : P_LAF;
            else if (m_phase == P_LAF)    nxt = parity_done ? P_DECODE : (low_pkt_valid ? P_PARITY : P_LD);
            else if (m_phase == P_WAIT)   nxt = empty_of(m_addr) ? P_LFD : P_WAIT;
        end
        m_phase = nxt;
        m_addr  = new_addr;
    endtask

    // One clock: model follows the edge, DUT sampled 1 time unit later
    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        check("state", 32'(fsm_state), 32'(m_phase));
        check("strobes", 32'({detect_add, lfd_state, ld_state, laf_state, full_state,
                              write_enb_reg, rst_int_reg, busy}), 32'(exp_tab[m_phase]));
    endtask

    task automatic idle_inputs();
        pkt_valid = 0; data_in = 0; fifo_full = 0; parity_done = 0; low_pkt_valid = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    endtask

    int we_cnt;
    int rst_cnt;
    int wait_cnt;
    int full_cnt;

    initial begin
        // Reset held two cycles
        idle_inputs();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_detect_add", 32'(detect_add), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_write_enb", 32'(write_enb_reg), 32'd0);

        // Normal packet to port 1 with four payload bytes
        we_cnt = 0; rst_cnt = 0;
        pkt_valid = 1; data_in = 2'd1;
        cyc();
        check("pkt1_lfd", 32'(fsm_state), 32'd1);
        data_in = 2'd0;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) pkt_valid = 0;
            cyc();
            if (write_enb_reg) we_cnt++;
            if (rst_int_reg) rst_cnt++;
        end
        check("pkt1_back_decode", 32'(fsm_state), 32'd0);
        check("pkt1_we_cycles", 32'(we_cnt), 32'd5);
        check("pkt1_rst_int_pulses", 32'(rst_cnt), 32'd1);

        // Header to port 2 while FIFO 2 stays occupied for six cycles
        wait_cnt = 0;
        pkt_valid = 1; data_in = 2'd2; fifo_empty_2 = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (fsm_state == 3'd7 && busy) wait_cnt++;
        end
        check("pkt2_wait_cycles", 32'(wait_cnt), 32'd6);
        fifo_empty_2 = 1;
        cyc();
        check("pkt2_lfd_after_wait", 32'(fsm_state), 32'd1);
        cyc();
        // Now in LOAD_DATA: FIFO full for three cycles
        full_cnt = 0;
        fifo_full = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (full_state) full_cnt++;
        end
        check("pkt2_full_cycles", 32'(full_cnt), 32'd3);
        fifo_full = 0;
        cyc();
        check("pkt2_laf", 32'(fsm_state), 32'd6);
        low_pkt_valid = 1; pkt_valid = 0;
        cyc();
        check("pkt2_laf_to_parity", 32'(fsm_state), 32'd3);
        low_pkt_valid = 0;
        cyc();
        cyc();
        check("pkt2_done", 32'(fsm_state), 32'd0);

        // Full again, then parity_done in LAF returns straight to decode
        pkt_valid = 1; data_in = 2'd0;
        cyc(); cyc();
        fifo_full = 1; cyc();
        fifo_full = 0; cyc();
        parity_done = 1; cyc();
        parity_done = 0;
        check("laf_parity_done", 32'(fsm_state), 32'd0);

        // Invalid header address is ignored
        we_cnt = 0;
        pkt_valid = 1; data_in = 2'd3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (write_enb_reg) we_cnt++;
        end
        check("invalid_hdr_state", 32'(fsm_state), 32'd0);
        check("invalid_hdr_we", 32'(we_cnt), 32'd0);

        // Soft reset while loading a packet for port 0
        data_in = 2'd0;
        cyc(); cyc();
        check("soft_in_ld", 32'(fsm_state), 32'd2);
        soft_reset_1 = 1;
        cyc();
        check("soft_other_port", 32'(fsm_state), 32'd2);
        soft_reset_0 = 1;
        cyc();
        soft_reset_0 = 0; soft_reset_1 = 0;
`ifdef ROUTER_FSM_SOFT_RESET_EN
        check("soft_own_port", 32'(fsm_state), 32'd0);
`else
        check("soft_ignored", 32'(fsm_state), 32'd2);
`endif

        // Reset mid-packet abandons it
        idle_inputs();
        pkt_valid = 1; data_in = 2'd1;
        cyc(); cyc();
        reset = 1;
        cyc();
        reset = 0;
        check("mid_pkt_reset", 32'(fsm_state), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty_0  = ($urandom_range(0, 2) != 0);
            fifo_empty_1  = ($urandom_range(0, 2) != 0);
            fifo_empty_2  = ($urandom_range(0, 2) != 0);
            soft_reset_0  = ($urandom_range(0, 19) == 0);
            soft_reset_1  = ($urandom_range(0, 19) == 0);
            soft_reset_2  = ($urandom_range(0, 19) == 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
